// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register of the 64-bit RISC-V core.
// Sized little-endian loads/stores on a private byte memory, plus branch resolution.
module mem_wb_stage #(
  parameter int DEPTH_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] adderout_in,
  input  logic        zero_in,
  input  logic [63:0] alu_result_in,
  input  logic [63:0] writedata_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_in,
  input  logic        branch_in,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic        memtoreg_in,
  input  logic        regwrite_in,
  output logic        pcsrc,
  output logic [63:0] branch_target,
  output logic [63:0] wb_read_data,
  output logic [63:0] wb_alu_result,
  output logic [4:0]  wb_rd,
  output logic        wb_memtoreg,
  output logic        wb_regwrite,
  output logic        wb_misaligned
);

  localparam int AW = $clog2(DEPTH_BYTES);

  // No handshake: one instruction is accepted every cycle, there is no stall path.
  logic [7:0]    mem_q [DEPTH_BYTES];
  logic [AW-1:0] addr;
  logic [3:0]    nbytes;
  logic          mem_access;
  logic          misaligned;
  logic [63:0]   raw_data;
  logic [63:0]   ext_data;
  logic [63:0]   load_data_d;

  logic [63:0] wb_read_data_q, wb_alu_result_q;
  logic [4:0]  wb_rd_q;
  logic        wb_memtoreg_q, wb_regwrite_q, wb_misaligned_q;

  // Upper address bits are deliberately ignored so accesses wrap around the array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^alu_result_in[63:AW];

  assign addr          = alu_result_in[AW-1:0];
  assign nbytes        = 4'd1 << funct3_in[1:0];
  assign mem_access    = memread_in | memwrite_in;
  assign pcsrc         = branch_in & zero_in;
  assign branch_target = adderout_in;

  always_comb begin
    misaligned = 1'b0;
    case (funct3_in[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = alu_result_in[0];
      2'b10:   misaligned = |alu_result_in[1:0];
      default: misaligned = |alu_result_in[2:0];
    endcase
    misaligned = misaligned & mem_access;
  end

  // Always fetch eight consecutive bytes; the size decode below picks the low ones.
  always_comb begin
    raw_data = '0;
    for (int i = 0; i < 8; i++) begin
      raw_data[8*i +: 8] = mem_q[addr + AW'(i)];
    end
  end

  always_comb begin
    ext_data = raw_data;
    case (funct3_in)
      3'b000:  ext_data = {{56{raw_data[7]}},  raw_data[7:0]};
      3'b001:  ext_data = {{48{raw_data[15]}}, raw_data[15:0]};
      3'b010:  ext_data = {{32{raw_data[31]}}, raw_data[31:0]};
      3'b100:  ext_data = {56'b0, raw_data[7:0]};
      3'b101:  ext_data = {48'b0, raw_data[15:0]};
      3'b110:  ext_data = {32'b0, raw_data[31:0]};
      default: ext_data = raw_data;
    endcase
  end

  assign load_data_d = (memread_in && !misaligned) ? ext_data : 64'd0;

  // Memory has no reset of its own; reset only blocks a store in that cycle.
  always_ff @(posedge clk) begin
    if (!reset && memwrite_in && !misaligned) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(nbytes)) begin
          mem_q[addr + AW'(i)] <= writedata_in[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_read_data_q  <= '0;
      wb_alu_result_q <= '0;
      wb_rd_q         <= '0;
      wb_memtoreg_q   <= 1'b0;
      wb_regwrite_q   <= 1'b0;
      wb_misaligned_q <= 1'b0;
    end else begin
      wb_read_data_q  <= load_data_d;
      wb_alu_result_q <= alu_result_in;
      wb_rd_q         <= rd_in;
      wb_memtoreg_q   <= memtoreg_in;
      wb_regwrite_q   <= regwrite_in & ~misaligned;
      wb_misaligned_q <= misaligned;
    end
  end

  assign wb_read_data  = wb_read_data_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_rd         = wb_rd_q;
  assign wb_memtoreg   = wb_memtoreg_q;
  assign wb_regwrite   = wb_regwrite_q;
  assign wb_misaligned = wb_misaligned_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, sized loads/stores, merge, misalignment,
// wrap-around, illegal read+write, branch resolution and pass-through.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic [63:0] adderout_in;
  logic        zero_in;
  logic [63:0] alu_result_in;
  logic [63:0] writedata_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_in;
  logic        branch_in, memread_in, memwrite_in, memtoreg_in, regwrite_in;
  logic        pcsrc;
  logic [63:0] branch_target;
  logic [63:0] wb_read_data;
  logic [63:0] wb_alu_result;
  logic [4:0]  wb_rd;
  logic        wb_memtoreg, wb_regwrite, wb_misaligned;

  int errors = 0;
  int checks = 0;

  mem_wb_stage #(.DEPTH_BYTES(1024)) dut (
    .clk(clk), .reset(reset),
    .adderout_in(adderout_in), .zero_in(zero_in),
    .alu_result_in(alu_result_in), .writedata_in(writedata_in),
    .funct3_in(funct3_in), .rd_in(rd_in),
    .branch_in(branch_in), .memread_in(memread_in), .memwrite_in(memwrite_in),
    .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
    .pcsrc(pcsrc), .branch_target(branch_target),
    .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result), .wb_rd(wb_rd),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_misaligned(wb_misaligned)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: present one EX/MEM bundle, clock it in, settle past the edge.
  task automatic op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                    input logic [63:0] addr, input logic [63:0] wdata,
                    input logic [4:0] rd, input logic rw, input logic mtr);
    memread_in    = rd_en;
    memwrite_in   = wr_en;
    funct3_in     = f3;
    alu_result_in = addr;
    writedata_in  = wdata;
    rd_in         = rd;
    regwrite_in   = rw;
    memtoreg_in   = mtr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    adderout_in = '0; zero_in = 1'b0; branch_in = 1'b0;
    idle(); idle();
    chk("rst_read_data", wb_read_data, 64'd0);
    chk("rst_alu", wb_alu_result, 64'd0);
    chk("rst_ctrl", {59'd0, wb_memtoreg, wb_regwrite, wb_misaligned}, 64'd0);

    // Seed 0x10, then store under reset must be suppressed and wb_* cleared
    reset = 1'b0;
    op(1'b0, 1'b1, 3'b011, 64'h10, 64'h0123456789ABCDEF, 5'd0, 1'b0, 1'b0);
    reset = 1'b1;
    op(1'b0, 1'b1, 3'b011, 64'h10, 64'hFF, 5'd3, 1'b1, 1'b1);
    chk("rst_store_alu", wb_alu_result, 64'd0);
    chk("rst_store_rd", {59'd0, wb_rd}, 64'd0);
    chk("rst_store_ctrl", {59'd0, wb_memtoreg, wb_regwrite, wb_misaligned}, 64'd0);
    reset = 1'b0;
    op(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 5'd4, 1'b1, 1'b1);
    chk("ld_after_rst", wb_read_data, 64'h0123456789ABCDEF);
    chk("ld_after_rst_ctrl", {59'd0, wb_memtoreg, wb_regwrite, wb_misaligned}, 64'b110);
    chk("ld_after_rst_rd", {59'd0, wb_rd}, 64'd4);

    // Sized loads after SD 0x8877665544332211 @0x20
    op(1'b0, 1'b1, 3'b011, 64'h20, 64'h8877665544332211, 5'd0, 1'b0, 1'b0);
    chk("sd_no_read", wb_read_data, 64'd0);
    chk("sd_alu", wb_alu_result, 64'h20);
    op(1'b1, 1'b0, 3'b000, 64'h20, 64'd0, 5'd5, 1'b1, 1'b1);
    chk("lb_20", wb_read_data, 64'h11);
    op(1'b1, 1'b0, 3'b001, 64'h22, 64'd0, 5'd5, 1'b1, 1'b1);
    chk("lh_22", wb_read_data, 64'h4433);
    op(1'b1, 1'b0, 3'b010, 64'h24, 64'd0, 5'd5, 1'b1, 1'b1);
    chk("lw_24", wb_read_data, 64'hFFFFFFFF88776655);
    op(1'b1, 1'b0, 3'b110, 64'h24, 64'd0, 5'd5, 1'b1, 1'b1);
    chk("lwu_24", wb_read_data, 64'h0000000088776655);
    op(1'b1, 1'b0, 3'b001, 64'h26, 64'd0, 5'd5, 1'b1, 1'b1);
    chk("lh_26", wb_read_data, 64'hFFFFFFFFFFFF8877);
    op(1'b1, 1'b0, 3'b101, 64'h26, 64'd0, 5'd5, 1'b1, 1'b1);
    chk("lhu_26", wb_read_data, 64'h8877);
    op(1'b1, 1'b0, 3'b011, 64'h20, 64'd0, 5'd5, 1'b1, 1'b1);
    chk("ld_20", wb_read_data, 64'h8877665544332211);
    op(1'b1, 1'b0, 3'b111, 64'h20, 64'd0, 5'd5, 1'b1, 1'b1);
    chk("f3_111_20", wb_read_data, 64'h8877665544332211);

    // Byte merge: only the low byte of writedata lands
    op(1'b0, 1'b1, 3'b011, 64'h40, 64'd0, 5'd0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 3'b000, 64'h43, 64'h1234567890ABCD80, 5'd0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 3'b011, 64'h40, 64'd0, 5'd6, 1'b1, 1'b1);
    chk("merge_ld_40", wb_read_data, 64'h0000000080000000);
    op(1'b1, 1'b0, 3'b000, 64'h43, 64'd0, 5'd6, 1'b1, 1'b1);
    chk("merge_lb_43", wb_read_data, 64'hFFFFFFFFFFFFFF80);
    op(1'b1, 1'b0, 3'b100, 64'h43, 64'd0, 5'd6, 1'b1, 1'b1);
    chk("merge_lbu_43", wb_read_data, 64'h80);

    // Misaligned store and loads
    op(1'b0, 1'b1, 3'b010, 64'h42, 64'hDEADBEEF, 5'd0, 1'b0, 1'b0);
    chk("sw_42_mis", {63'd0, wb_misaligned}, 64'd1);
    op(1'b1, 1'b0, 3'b011, 64'h40, 64'd0, 5'd6, 1'b1, 1'b1);
    chk("sw_42_unchanged", wb_read_data, 64'h0000000080000000);
    chk("aligned_not_mis", {63'd0, wb_misaligned}, 64'd0);
    op(1'b1, 1'b0, 3'b011, 64'h44, 64'd0, 5'd8, 1'b1, 1'b1);
    chk("ld_44_data", wb_read_data, 64'd0);
    chk("ld_44_ctrl", {62'd0, wb_regwrite, wb_misaligned}, 64'b01);
    op(1'b1, 1'b0, 3'b001, 64'h41, 64'd0, 5'd8, 1'b1, 1'b1);
    chk("lh_41_ctrl", {wb_read_data[61:0], wb_regwrite, wb_misaligned}, 64'b01);

    // Wrap-around: 0x400 aliases 0x0
    op(1'b0, 1'b1, 3'b011, 64'h400, 64'hAB, 5'd0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 3'b011, 64'h0, 64'd0, 5'd9, 1'b1, 1'b1);
    chk("wrap_ld_0", wb_read_data, 64'hAB);

    // Illegal read+write: old data returned, store still commits
    op(1'b1, 1'b1, 3'b011, 64'h20, 64'h55, 5'd10, 1'b1, 1'b1);
    chk("rw_old_data", wb_read_data, 64'h8877665544332211);
    op(1'b1, 1'b0, 3'b011, 64'h20, 64'd0, 5'd10, 1'b1, 1'b1);
    chk("rw_new_data", wb_read_data, 64'h55);

    // Branch resolution is combinational
    branch_in = 1'b1; zero_in = 1'b1; adderout_in = 64'h1000;
    #1;
    chk("br_taken", {63'd0, pcsrc}, 64'd1);
    chk("br_target", branch_target, 64'h1000);
    zero_in = 1'b0;
    #1;
    chk("br_not_taken", {63'd0, pcsrc}, 64'd0);
    branch_in = 1'b0; zero_in = 1'b1;
    #1;
    chk("no_branch", {63'd0, pcsrc}, 64'd0);
    zero_in = 1'b0;

    // R-type pass-through
    op(1'b0, 1'b0, 3'b000, 64'h5, 64'hFFFF, 5'd7, 1'b1, 1'b0);
    chk("rtype_alu", wb_alu_result, 64'h5);
    chk("rtype_rd", {59'd0, wb_rd}, 64'd7);
    chk("rtype_ctrl", {59'd0, wb_memtoreg, wb_regwrite, wb_misaligned}, 64'b010);
    chk("rtype_read", wb_read_data, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the 64-bit RISC-V 5-stage core. It consumes the EX/MEM register outputs and performs sized, little-endian loads and stores on an internal byte-addressed data memory. It resolves the branch decision (PC source and flush to earlier stages) and registers everything writeback needs.

## Interface
Parameters:
- DEPTH_BYTES, 1024: data memory size in bytes; power of two, ≥ 8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- adderout_in  in  64  branch target from EX/MEM
- zero_in  in  1  ALU zero flag
- alu_result_in  in  64  ALU result; memory byte address for loads/stores
- writedata_in  in  64  store data (rs2)
- funct3_in  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- rd_in  in  5  destination register
- branch_in, memread_in, memwrite_in, memtoreg_in, regwrite_in  in  1 each  control bits
- pcsrc  out  1  combinational: branch_in & zero_in
- branch_target  out  64  combinational: adderout_in
- wb_read_data  out  64  registered, extended load data
- wb_alu_result  out  64  registered alu_result_in
- wb_rd  out  5  registered rd_in
- wb_memtoreg, wb_regwrite  out  1 each  registered controls
- wb_misaligned  out  1  registered misaligned-access flag

## Operation
- Memory: DEPTH_BYTES × 8-bit array, little-endian. Not cleared by reset. Index = alu_result_in[log2(DEPTH_BYTES)-1:0]; upper address bits ignored (wrap-around).
- Access size from funct3_in[1:0]: 1, 2, 4 or 8 bytes.
- Alignment: misaligned when the address is not a multiple of the access size.
- Misaligned access (memread_in or memwrite_in):
  - store suppressed; no byte changes.
  - load data forced to 0.
  - wb_regwrite forced to 0.
  - wb_misaligned = 1.
- Store (memwrite_in=1, aligned): at posedge, writes the low N bytes of writedata_in to addr..addr+N-1. Other bytes are unchanged.
- Load (memread_in=1, aligned): reads N bytes combinationally.
  - funct3_in[2]=0: sign-extend to 64 bits.
  - funct3_in[2]=1: zero-extend to 64 bits.
  - Captured into wb_read_data at posedge.
- memread_in=0: wb_read_data captures 0.
- memread_in and memwrite_in both 1: illegal. The store takes effect, and wb_read_data returns the pre-store memory contents.
- funct3=111 with a memory access: treated as D size, zero-extended.
- Branch: pcsrc = branch_in & zero_in, independent of the memory controls. Upstream uses it to flush IF/ID, ID/EX and EX/MEM.

## Timing
- Reset, synchronous: at the posedge with reset=1, all wb_* outputs become 0 and no store is performed. Reset has priority over a store presented in the same cycle.
- Latency: one cycle from EX/MEM outputs to wb_* outputs; the memory write commits at the same edge.
- Store then load to the same address in the next cycle: the load returns the new data, with no hazard bubble.
- pcsrc and branch_target have zero latency (combinational) and are unaffected by reset except through their inputs.
- Reset asserted between a store and a dependent load: memory keeps the stored bytes, and the load after reset returns them.
- No stall or handshake: one instruction accepted every cycle.

## Test plan
- Reset: drive reset=1 with memwrite_in=1, addr 0x10, data 0xFF → wb_* all 0; a later LD 0x10 returns the prior contents, not 0xFF.
- Sized store/load:
  - SD 0x8877665544332211 @0x20, then LB @0x20 → 0x11; LH @0x22 → 0x4433; LW @0x24 → 0xFFFFFFFF88776655; LWU @0x24 → 0x0000000088776655; LD @0x20 → the full value.
- Byte merge: SD 0 @0x40, SB 0x80 @0x43 → LD @0x40 = 0x0000000080000000; LB @0x43 = 0xFFFFFFFFFFFFFF80; LBU @0x43 = 0x80.
- Misaligned: SW @0x42 leaves memory unchanged; LD @0x44 → wb_read_data 0, wb_regwrite 0, wb_misaligned 1.
- Wrap-around with DEPTH_BYTES=1024: SD 0xAB @0x400 then LD @0x0 → 0xAB.
- Branch: branch_in=1, zero_in=1, adderout_in=0x1000 → pcsrc=1 and branch_target=0x1000 in the same cycle; with zero_in=0 → pcsrc=0.
- Pass-through: R-type with alu_result_in=0x5, rd_in=7, regwrite_in=1 → next cycle wb_alu_result=5, wb_rd=7, wb_regwrite=1, wb_read_data=0.
